nand4_bist_ctrl: RTL



---
 rtl/nand4_bist_pkg.sv | 19 +
 rtl/nand4_pat_gen.sv | 43 ++++
 rtl/nand4_bist_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/nand4_bist_pkg.sv
// Shared definitions for the NAND4 self-test sequencer: state encoding and
// default configuration constants.
package nand4_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } bist_state_e;

  // Default settle time (cycles each pattern is held before sampling).
  localparam int DEF_SETTLE = 2;
  // Default width of the saturating mismatch counter.
  localparam int DEF_ERR_W  = 8;
  // Settle counter width; covers the legal SETTLE range 1..15.
  localparam int SETTLE_W   = 4;

endpackage : nand4_bist_pkg

// File: rtl/nand4_pat_gen.sv
// Pattern counter plus settle down-counter for the NAND4 self-test.
// load restarts at pattern 0, advance steps to the next pattern; both reload
// the settle counter with SETTLE-1. Otherwise the settle counter counts down
// to zero and then holds there.
module nand4_pat_gen
  import nand4_bist_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int SETTLE = DEF_SETTLE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             advance,
  output logic [WIDTH-1:0] pat,
  output logic             last_pat,
  output logic             settle_zero
);

  localparam logic [SETTLE_W-1:0] SETTLE_RELOAD = SETTLE_W'(SETTLE - 1);

  logic [SETTLE_W-1:0] settle_q;

  // Pattern register and settle down-counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat      <= '0;
      settle_q <= '0;
    end else if (load) begin
      pat      <= '0;
      settle_q <= SETTLE_RELOAD;
    end else if (advance) begin
      pat      <= pat + WIDTH'(1);
      settle_q <= SETTLE_RELOAD;
    end else if (settle_q != '0) begin
      settle_q <= settle_q - SETTLE_W'(1);
    end
  end

  assign last_pat    = &pat;
  assign settle_zero = (settle_q == '0);

endmodule : nand4_pat_gen

// File: rtl/nand4_bist_ctrl.sv
// Self-test sequencer for a 4-input NAND gate. Walks every input pattern,
// holds each one for SETTLE cycles, samples the gate output in a CHECK cycle
// and accumulates a saturating mismatch count plus the first failing pattern.
//
// Control semantics: start is a single-cycle request sampled only in IDLE
// (ignored elsewhere, never queued); abort is sampled only in APPLY/CHECK and
// returns to IDLE without a done pulse. start wins over abort in IDLE.
// done is a one-cycle pulse; pass/err_cnt/fail_* stay valid until the next
// start or reset.
module nand4_bist_ctrl
  import nand4_bist_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int SETTLE = DEF_SETTLE,
  parameter int ERR_W  = DEF_ERR_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic [WIDTH-1:0] dut_a,
  input  logic             dut_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic             fail_valid,
  output logic [WIDTH-1:0] fail_pat
);

  // Configuration guard: the settle counter only covers 1..15.
  if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
    $error("nand4_bist_ctrl: SETTLE=%0d outside legal range 1..15", SETTLE);
  end

  bist_state_e state_q;
  bist_state_e state_d;

  logic             pg_load;
  logic             pg_advance;
  logic             last_pat;
  logic             settle_zero;
  logic             start_run;
  logic             mismatch;
  logic [ERR_W-1:0] err_next;

  nand4_pat_gen #(
    .WIDTH  (WIDTH),
    .SETTLE (SETTLE)
  ) u_pat_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (pg_load),
    .advance     (pg_advance),
    .pat         (dut_a),
    .last_pat    (last_pat),
    .settle_zero (settle_zero)
  );

  // A mismatch is only meaningful in the CHECK cycle, against the ideal NAND.
  assign start_run = (state_q == ST_IDLE) && start;
  assign mismatch  = (state_q == ST_CHECK) && (dut_y != ~(&dut_a));

  // Next error count, saturating at all-ones; also feeds the pass decision.
  always_comb begin
    err_next = err_cnt;
    if (mismatch && (err_cnt != '1)) begin
      err_next = err_cnt + ERR_W'(1);
    end
  end

  // Next-state and pattern generator control.
  always_comb begin
    state_d    = state_q;
    pg_load    = 1'b0;
    pg_advance = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_APPLY;
          pg_load = 1'b1;
        end
      end
      ST_APPLY: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (settle_zero) begin
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (last_pat) begin
          state_d = ST_DONE;
        end else begin
          state_d    = ST_APPLY;
          pg_advance = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Registered status flags derived from the upcoming state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_d == ST_APPLY) || (state_d == ST_CHECK);
      done <= (state_d == ST_DONE);
    end
  end

  // Result registers: cleared on a new run, updated on each mismatch; the
  // pass verdict is taken from the count including the final CHECK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt    <= '0;
      fail_valid <= 1'b0;
      fail_pat   <= '0;
      pass       <= 1'b0;
    end else if (start_run) begin
      err_cnt    <= '0;
      fail_valid <= 1'b0;
      fail_pat   <= '0;
      pass       <= 1'b0;
    end else begin
      err_cnt <= err_next;
      if (mismatch && !fail_valid) begin
        fail_valid <= 1'b1;
        fail_pat   <= dut_a;
      end
      if ((state_q == ST_CHECK) && (state_d == ST_DONE)) begin
        pass <= (err_next == '0);
      end
    end
  end

endmodule : nand4_bist_ctrl
